tile_step_mover: RTL and testbench
==================================

Name: tile_step_mover

Overview:
- Upstream position source for the rounded square sprite stage.
- Moves the player sprite across the arena one 32-pixel tile per move command, advancing SPEED pixels per video frame.
- Drives signed topLeftX/topLeftY. These are always tile-aligned when idle, so the downstream snap-to-grid rounding reproduces the exact position at rest.
- Also reports the current logical tile and a per-step completion pulse to the game-control logic.

Parameters:
- INITIAL_X, 32, reset X position in pixels; must be a multiple of 32.
- INITIAL_Y, 32, reset Y position in pixels; must be a multiple of 32.
- SPEED, 4, pixels advanced per frame tick; legal range 1..32.
- MIN_X, 32, leftmost legal tile-aligned X.
- MAX_X, 576, rightmost legal tile-aligned X.
- MIN_Y, 32, topmost legal tile-aligned Y.
- MAX_Y, 416, bottommost legal tile-aligned Y.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame; all motion updates occur only on this cycle.
- upKey, downKey, leftKey, rightKey  in  1 each  level move requests.
- blockedUp, blockedDown, blockedLeft, blockedRight  in  1 each  neighbour tile is not walkable (from map/collision logic).
- freeze  in  1  hold all motion (pause/game over).
- topLeftX  out  11 signed  sprite top-left X in pixels.
- topLeftY  out  11 signed  sprite top-left Y in pixels.
- tileX  out  5  (topLeftX+16)>>5.
- tileY  out  5  (topLeftY+16)>>5.
- moving  out  1  high while in state MOVING.
- direction  out  2  current/last direction: 0 up, 1 down, 2 left, 3 right.
- stepDone  out  1  one-cycle pulse when the sprite reaches its target tile.

Behaviour:
- Reset values:
  - topLeftX=INITIAL_X, topLeftY=INITIAL_Y.
  - tileX/tileY derived from those positions.
  - moving=0, direction=1 (down), stepDone=0, state IDLE.
  - Internal targetX/targetY equal to the reset position.
- Reset asserted mid-move aborts the move immediately, with no stepDone.
- All outputs are registered. Position changes become visible on the cycle after the startOfFrame pulse.
- Nothing changes on cycles where startOfFrame=0, except stepDone returning to 0.
- freeze=1 on a frame tick:
  - No state or position change and no pulse.
  - A move in progress resumes on the next unfrozen tick.
- State IDLE, on a frame tick:
  - Select one key by priority up > down > left > right; simultaneous keys resolve to the highest priority.
  - The move is legal iff the matching blocked input is 0 and the target stays within the MIN/MAX range. Target = position ±32 on the axis of motion.
  - If legal: latch target, set direction, go to MOVING, and apply the first SPEED step on this same tick.
  - If a key is pressed but the move is illegal: update direction only (the sprite turns in place) and stay IDLE.
  - If no key is pressed: no change.
- State MOVING, on a frame tick:
  - Move SPEED pixels toward the target.
  - If the remaining distance ≤ SPEED, land exactly on the target (clamp; no overshoot when SPEED does not divide 32).
  - On landing: pulse stepDone for exactly one cycle (the cycle the landed position appears) and return to IDLE.
  - Keys and blocked inputs are ignored while MOVING; direction is locked.
- moving deasserts in the same cycle stepDone is asserted.
- Back-to-back steps: with a key held, the next step starts on the next frame tick after landing.
- Arithmetic:
  - Positions are held as signed 11-bit values.
  - Intermediate sums use 12-bit arithmetic to avoid wrap.
  - Positions never leave [MIN,MAX] by construction.
- tileX/tileY are computed continuously from the registered position, so mid-step they switch tile at the halfway point. This matches the downstream rounding.

Test Plan:
- Reset, then no keys for 5 frames -> topLeft=(32,32), tile=(1,1), moving=0, direction=1, stepDone never high.
- rightKey held, SPEED=4 -> X advances 36,40,…,64 over 8 frame ticks; stepDone pulses once on the tick reaching 64; moving=0 that cycle; next tick starts 64→68.
- At (32,32), upKey=1 -> MIN_Y violation; position unchanged, direction=0, moving=0. leftKey with blockedLeft=0 at X=32 -> also refused.
- upKey+rightKey together with blockedUp=1 -> turn only, direction=0, no motion (priority is not re-resolved to right).
- SPEED=5, downKey from Y=32 -> Y=37,42,47,52,57,62,64; stepDone on 64; tileY changes 1→2 at Y=52.
- Mid-move: freeze=1 for 3 frames holds X constant; then reset asserted between frame ticks -> immediately topLeft=(32,32), moving=0, no stepDone.

Source files
------------

// File: rtl/tile_step_mover_if.sv
// tile_step_mover_if: frame/key/collision inputs and position/status outputs of the tile step mover
interface tile_step_mover_if;
   logic startOfFrame;
   logic upKey, downKey, leftKey, rightKey;
   logic blockedUp, blockedDown, blockedLeft, blockedRight;
   logic freeze;
   logic signed [10:0] topLeftX, topLeftY;
   logic [4:0] tileX, tileY;
   logic moving;
   logic [1:0] direction;
   logic stepDone;
   modport master (
      output startOfFrame, upKey, downKey, leftKey, rightKey,
      output blockedUp, blockedDown, blockedLeft, blockedRight, freeze,
      input  topLeftX, topLeftY, tileX, tileY, moving, direction, stepDone
   );
   modport slave (
      input  startOfFrame, upKey, downKey, leftKey, rightKey,
      input  blockedUp, blockedDown, blockedLeft, blockedRight, freeze,
      output topLeftX, topLeftY, tileX, tileY, moving, direction, stepDone
   );
endinterface

// File: rtl/tile_step_mover.sv
// tile_step_mover: moves a sprite one 32-pixel tile per key command, SPEED pixels per frame tick
module tile_step_mover #(
   parameter int INITIAL_X = 32,
   parameter int INITIAL_Y = 32,
   parameter int SPEED     = 4,
   parameter int MIN_X     = 32,
   parameter int MAX_X     = 576,
   parameter int MIN_Y     = 32,
   parameter int MAX_Y     = 416
) (
   input logic clk,
   input logic reset,
   tile_step_mover_if.slave bus
);
   typedef enum logic {IDLE, MOVING} state_t;
   localparam logic signed [11:0] SPD  = 12'(SPEED);
   localparam logic signed [11:0] MINX = 12'(MIN_X);
   localparam logic signed [11:0] MAXX = 12'(MAX_X);
   localparam logic signed [11:0] MINY = 12'(MIN_Y);
   localparam logic signed [11:0] MAXY = 12'(MAX_Y);
   state_t state_q, state_d;
   logic signed [10:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic signed [10:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
   logic [1:0] dir_q, dir_d;
   logic done_q, done_d;
   logic tick, any_key, blk, legal, start, adv, landed;
   logic [1:0] sel;
   logic signed [11:0] x12, y12, cand_x, cand_y, eff_tx, eff_ty, dx, dy, nx, ny;
   // key arbitration, legality of a new step, and the clamped per-tick advance toward the target
   always_comb begin
      tick    = bus.startOfFrame && !bus.freeze;
      x12     = {pos_x_q[10], pos_x_q};
      y12     = {pos_y_q[10], pos_y_q};
      any_key = bus.upKey | bus.downKey | bus.leftKey | bus.rightKey;
      sel     = bus.upKey ? 2'd0 : bus.downKey ? 2'd1 : bus.leftKey ? 2'd2 : 2'd3;
      blk     = bus.upKey ? bus.blockedUp : bus.downKey ? bus.blockedDown :
                bus.leftKey ? bus.blockedLeft : bus.blockedRight;
      cand_x  = sel == 2'd2 ? x12 - 12'sd32 : sel == 2'd3 ? x12 + 12'sd32 : x12;
      cand_y  = sel == 2'd0 ? y12 - 12'sd32 : sel == 2'd1 ? y12 + 12'sd32 : y12;
      legal   = any_key && !blk && cand_x >= MINX && cand_x <= MAXX && cand_y >= MINY && cand_y <= MAXY;
      start   = state_q == IDLE && legal;
      eff_tx  = start ? cand_x : {tgt_x_q[10], tgt_x_q};
      eff_ty  = start ? cand_y : {tgt_y_q[10], tgt_y_q};
      dx      = eff_tx - x12;
      dy      = eff_ty - y12;
      nx      = dx > SPD ? x12 + SPD : dx < -SPD ? x12 - SPD : eff_tx;
      ny      = dy > SPD ? y12 + SPD : dy < -SPD ? y12 - SPD : eff_ty;
      adv     = tick && (start || state_q == MOVING);
      landed  = nx == eff_tx && ny == eff_ty;
      pos_x_d = adv ? 11'(nx) : pos_x_q;
      pos_y_d = adv ? 11'(ny) : pos_y_q;
      tgt_x_d = adv ? 11'(eff_tx) : tgt_x_q;
      tgt_y_d = adv ? 11'(eff_ty) : tgt_y_q;
      dir_d   = tick && state_q == IDLE && any_key ? sel : dir_q;
      state_d = adv ? (landed ? IDLE : MOVING) : state_q;
      done_d  = adv && landed;
   end
   // register state, position, target and status; reset aborts any move without a pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pos_x_q <= 11'(INITIAL_X);
         pos_y_q <= 11'(INITIAL_Y);
         tgt_x_q <= 11'(INITIAL_X);
         tgt_y_q <= 11'(INITIAL_Y);
         dir_q   <= 2'd1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         tgt_x_q <= tgt_x_d;
         tgt_y_q <= tgt_y_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end
   assign bus.topLeftX  = pos_x_q;
   assign bus.topLeftY  = pos_y_q;
   assign bus.tileX     = 5'(($unsigned(pos_x_q) + 11'd16) >> 5);
   assign bus.tileY     = 5'(($unsigned(pos_y_q) + 11'd16) >> 5);
   assign bus.moving    = state_q == MOVING;
   assign bus.direction = dir_q;
   assign bus.stepDone  = done_q;
endmodule

// File: tb/tb_tile_step_mover.sv
// tb_tile_step_mover: scoreboard bench driving SPEED=4 and SPEED=5 movers with shared stimulus
module tb_tile_step_mover;
   logic clk = 1'b0;
   logic reset;
   logic sof, up, dn, lf, rt, bu, bd, bl, br, frz;
   always #5 clk = ~clk;
   tile_step_mover_if bus4();
   tile_step_mover_if bus5();
   tile_step_mover #(.SPEED(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
   tile_step_mover #(.SPEED(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));
   assign bus4.startOfFrame = sof;  assign bus5.startOfFrame = sof;
   assign bus4.upKey = up;          assign bus5.upKey = up;
   assign bus4.downKey = dn;        assign bus5.downKey = dn;
   assign bus4.leftKey = lf;        assign bus5.leftKey = lf;
   assign bus4.rightKey = rt;       assign bus5.rightKey = rt;
   assign bus4.blockedUp = bu;      assign bus5.blockedUp = bu;
   assign bus4.blockedDown = bd;    assign bus5.blockedDown = bd;
   assign bus4.blockedLeft = bl;    assign bus5.blockedLeft = bl;
   assign bus4.blockedRight = br;   assign bus5.blockedRight = br;
   assign bus4.freeze = frz;        assign bus5.freeze = frz;

   typedef struct {int inst; int x; int y; int mov; int dir; int done;} exp_t;
   exp_t q[$];
   int tests = 0, fails = 0;
   int sp[2] = '{4, 5};
   int mx[2], my[2], mdx[2], mdy[2], mdir[2], mk[2];
   bit mmov[2];
   logic seen;

   task automatic chk(input string n, input int a, input int e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         mx[i] = 32; my[i] = 32; mdx[i] = 0; mdy[i] = 0; mdir[i] = 1; mk[i] = 0; mmov[i] = 0;
      end
   endfunction

   // tile-level model: a step is start tile + direction * min(32, ticks*speed)
   function automatic void model_tick();
      int d, ddx, ddy, nx, ny, off, done;
      bit b;
      for (int i = 0; i < 2; i++) begin
         done = 0;
         if (!frz) begin
            if (!mmov[i] && (up | dn | lf | rt)) begin
               d = up ? 0 : dn ? 1 : lf ? 2 : 3;
               b = up ? bu : dn ? bd : lf ? bl : br;
               ddx = d == 2 ? -1 : d == 3 ? 1 : 0;
               ddy = d == 0 ? -1 : d == 1 ? 1 : 0;
               nx = mx[i] + 32 * ddx;
               ny = my[i] + 32 * ddy;
               mdir[i] = d;
               if (!b && nx >= 32 && nx <= 576 && ny >= 32 && ny <= 416) begin
                  mmov[i] = 1; mk[i] = 0; mdx[i] = ddx; mdy[i] = ddy;
               end
            end
            if (mmov[i]) begin
               mk[i]++;
               if (mk[i] * sp[i] >= 32) begin
                  mx[i] += 32 * mdx[i]; my[i] += 32 * mdy[i];
                  mmov[i] = 0; mk[i] = 0; done = 1;
               end
            end
         end
         off = mmov[i] ? (mk[i] * sp[i] > 32 ? 32 : mk[i] * sp[i]) : 0;
         q.push_back('{i, mx[i] + mdx[i] * off, my[i] + mdy[i] * off, int'(mmov[i]), mdir[i], done});
      end
   endfunction

   task automatic frame(input bit f, input bit u, input bit d, input bit l, input bit r,
                        input bit b_u, input bit b_d, input bit b_l, input bit b_r, input int gap);
      @(negedge clk);
      frz = f; up = u; dn = d; lf = l; rt = r; bu = b_u; bd = b_d; bl = b_l; br = b_r;
      sof = 1'b1;
      model_tick();
      @(negedge clk);
      sof = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic check_reset();
      chk("rst_x4", bus4.topLeftX, 32);   chk("rst_y4", bus4.topLeftY, 32);
      chk("rst_tx4", bus4.tileX, 1);      chk("rst_ty4", bus4.tileY, 1);
      chk("rst_mov4", bus4.moving, 0);    chk("rst_dir4", bus4.direction, 1);
      chk("rst_done4", bus4.stepDone, 0);
      chk("rst_x5", bus5.topLeftX, 32);   chk("rst_y5", bus5.topLeftY, 32);
      chk("rst_mov5", bus5.moving, 0);    chk("rst_done5", bus5.stepDone, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset();
      q.delete();
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   always @(posedge clk or posedge reset)
      if (reset) seen <= 1'b0;
      else seen <= sof;

   // monitor: pop one expectation per instance after each frame tick, else require stepDone low
   always @(negedge clk) begin
      exp_t e;
      if (!reset && seen) begin
         for (int j = 0; j < 2; j++) begin
            if (q.size() == 0) chk("queue_underflow", 0, 1);
            else begin
               e = q.pop_front();
               chk(e.inst ? "x5" : "x4", e.inst ? bus5.topLeftX : bus4.topLeftX, e.x);
               chk(e.inst ? "y5" : "y4", e.inst ? bus5.topLeftY : bus4.topLeftY, e.y);
               chk(e.inst ? "tilex5" : "tilex4", e.inst ? bus5.tileX : bus4.tileX, (e.x + 16) >> 5);
               chk(e.inst ? "tiley5" : "tiley4", e.inst ? bus5.tileY : bus4.tileY, (e.y + 16) >> 5);
               chk(e.inst ? "mov5" : "mov4", e.inst ? bus5.moving : bus4.moving, e.mov);
               chk(e.inst ? "dir5" : "dir4", e.inst ? bus5.direction : bus4.direction, e.dir);
               chk(e.inst ? "done5" : "done4", e.inst ? bus5.stepDone : bus4.stepDone, e.done);
            end
         end
      end else if (!reset) begin
         chk("idle_done4", bus4.stepDone, 0);
         chk("idle_done5", bus5.stepDone, 0);
      end
   end

   initial begin
      {sof, up, dn, lf, rt, bu, bd, bl, br, frz} = '0;
      reset = 1'b1;
      model_reset();
      #3 check_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (5) frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (8) frame(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      chk("plan_right_land_x4", bus4.topLeftX, 64);
      frame(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      do_reset();
      frame(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      frame(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      frame(0, 1, 0, 0, 1, 1, 0, 0, 0, 2);
      chk("plan_turn_dir4", bus4.direction, 0);
      chk("plan_turn_x4", bus4.topLeftX, 32);
      repeat (7) frame(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("plan_speed5_y", bus5.topLeftY, 64);
      repeat (2) frame(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      frame(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      repeat (3) frame(1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      do_reset();
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         frame($urandom_range(0, 9) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 2));
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
